// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC frame scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package dac_pkg;

  localparam int DAC_FRAME_LEN    = 128;
  localparam int DAC_INTERP_RATIO = 4;
  localparam int DAC_REQ_LEAD     = 8;
  localparam int DAC_DATA_W       = 16;

  // STOP is not a separate state: it is RUN with a pending-stop flag.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Saturating 8-bit increment used by the underrun counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Bundle between the PCM source / DAC datapath and the frame scheduler.
// Latency: n/a (wiring only).
// Backpressure: s_valid/s_ready handshake; all other signals are unconditioned.
// Ports: enable, s_valid, s_data in to scheduler; s_ready, frame_stb, interp_stb,
//        sample_out, underrun, underrun_cnt, running, phase out of scheduler.
interface dac_frame_scheduler_if
  import dac_pkg::*;
#(
  parameter int DATA_W = DAC_DATA_W,
  parameter int PH_W   = $clog2(DAC_FRAME_LEN)
);
  logic              enable;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              frame_stb;
  logic              interp_stb;
  logic [DATA_W-1:0] sample_out;
  logic              underrun;
  logic [7:0]        underrun_cnt;
  logic              running;
  logic [PH_W-1:0]   phase;

  // Controller / source side.
  modport master (
    output enable, s_valid, s_data,
    input  s_ready, frame_stb, interp_stb, sample_out, underrun, underrun_cnt, running, phase
  );

  // Scheduler side.
  modport slave (
    input  enable, s_valid, s_data,
    output s_ready, frame_stb, interp_stb, sample_out, underrun, underrun_cnt, running, phase
  );
endinterface

// File: rtl/dac_phase_counter.sv
// Frame phase counter with frame, interpolator, request-window and wrap taps.
// Latency: phase advances one step per cycle while active; taps decode the registered phase.
// Backpressure: none; free-running while i_active, held at 0 otherwise.
// Ports: clk_in, reset, i_active in; o_phase, o_frame_stb, o_interp_stb, o_window, o_wrap out.
module dac_phase_counter
  import dac_pkg::*;
#(
  parameter int FRAME_LEN    = DAC_FRAME_LEN,
  parameter int INTERP_RATIO = DAC_INTERP_RATIO,
  parameter int REQ_LEAD     = DAC_REQ_LEAD,
  parameter int PH_W         = $clog2(FRAME_LEN)
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            i_active,
  output logic [PH_W-1:0] o_phase,
  output logic            o_frame_stb,
  output logic            o_interp_stb,
  output logic            o_window,
  output logic            o_wrap
);
  localparam int STEP      = FRAME_LEN / INTERP_RATIO;
  localparam int WIN_START = FRAME_LEN - REQ_LEAD;

  logic [PH_W-1:0] r_phase;

  // FRAME_LEN is a power of two, so the natural binary rollover is the wrap.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (i_active) begin
      r_phase <= r_phase + 1'b1;
    end else begin
      r_phase <= '0;
    end
  end

  // STEP is a power of two, so the modulo tap is a low-bit mask.
  assign o_phase      = r_phase;
  assign o_frame_stb  = i_active && (r_phase == '0);
  assign o_interp_stb = i_active && ((r_phase & PH_W'(STEP - 1)) == '0);
  assign o_window     = i_active && (r_phase >= PH_W'(WIN_START));
  assign o_wrap       = i_active && (r_phase == PH_W'(FRAME_LEN - 1));

endmodule

// File: rtl/dac_frame_scheduler.sv
// Sample-rate sequencer: fetches one PCM sample per frame, issues frame/interp strobes, mutes on underrun.
// Latency: first handshake in PRIME appears on sample_out with frame_stb one cycle later; later samples at the next wrap.
// Backpressure: s_ready open in PRIME and in the last REQ_LEAD phases of a frame while the holding register is empty.
// Ports: clk_in, reset (async, active-high); bus (slave modport) carrying enable, source handshake and all status outputs.
module dac_frame_scheduler
  import dac_pkg::*;
#(
  parameter int FRAME_LEN    = DAC_FRAME_LEN,
  parameter int INTERP_RATIO = DAC_INTERP_RATIO,
  parameter int REQ_LEAD     = DAC_REQ_LEAD,
  parameter int DATA_W       = DAC_DATA_W
) (
  input  logic                  clk_in,
  input  logic                  reset,
  dac_frame_scheduler_if.slave  bus
);
  localparam int PH_W = $clog2(FRAME_LEN);

  state_t            r_state;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_sample;
  logic              r_underrun;
  logic [7:0]        r_ucnt;
  logic              r_stop;

  logic              w_active;
  logic [PH_W-1:0]   w_phase;
  logic              w_frame_stb;
  logic              w_interp_stb;
  logic              w_window;
  logic              w_wrap;
  logic              w_ready;
  logic              w_accept;

  assign w_active = (r_state == RUN);

  dac_phase_counter #(
    .FRAME_LEN    (FRAME_LEN),
    .INTERP_RATIO (INTERP_RATIO),
    .REQ_LEAD     (REQ_LEAD),
    .PH_W         (PH_W)
  ) u_phase (
    .clk_in       (clk_in),
    .reset        (reset),
    .i_active     (w_active),
    .o_phase      (w_phase),
    .o_frame_stb  (w_frame_stb),
    .o_interp_stb (w_interp_stb),
    .o_window     (w_window),
    .o_wrap       (w_wrap)
  );

  // Ready is gated by enable in PRIME so a simultaneous stop request accepts nothing.
  // In RUN the empty holding register limits intake to one sample per frame.
  assign w_ready  = ((r_state == PRIME) && bus.enable) ||
                    (w_active && w_window && !r_hold_full);
  assign w_accept = w_ready && bus.s_valid;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_sample    <= '0;
      r_underrun  <= 1'b0;
      r_ucnt      <= '0;
      r_stop      <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_stop <= 1'b0;
          if (bus.enable) r_state <= PRIME;
        end
        PRIME: begin
          if (!bus.enable) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_state  <= RUN;
            r_sample <= bus.s_data;
          end
        end
        RUN: begin
          if (w_wrap) begin
            // A stop requested at any point in the frame (or at the wrap itself)
            // takes effect here, even if enable has come back by now.
            if (r_stop || !bus.enable) begin
              r_state     <= IDLE;
              r_sample    <= '0;
              r_hold_full <= 1'b0;
              r_stop      <= 1'b0;
            end else if (r_hold_full) begin
              r_sample    <= r_hold;
              r_hold_full <= 1'b0;
            end else if (w_accept) begin
              // Last-phase handshake bypasses the holding register.
              r_sample <= bus.s_data;
            end else begin
              r_sample   <= '0;
              r_underrun <= 1'b1;
              r_ucnt     <= sat_inc8(r_ucnt);
            end
          end else begin
            if (w_accept) begin
              r_hold      <= bus.s_data;
              r_hold_full <= 1'b1;
            end
            if (!bus.enable) r_stop <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready      = w_ready;
  assign bus.frame_stb    = w_frame_stb;
  assign bus.interp_stb   = w_interp_stb;
  assign bus.sample_out   = r_sample;
  assign bus.underrun     = r_underrun;
  assign bus.underrun_cnt = r_ucnt;
  assign bus.running      = w_active;
  assign bus.phase        = w_phase;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a frame-level scoreboard.
// Stimulus pushes the expected {sample_out, underrun, underrun_cnt} per frame; a monitor pops on frame_stb.
// Direct checks cover reset, PRIME latency, window/ready behaviour, stop and re-enable sequencing.
module tb_dac_frame_scheduler;
  import dac_pkg::*;

  localparam int FL = 128;
  localparam int IR = 4;
  localparam int RL = 8;
  localparam int DW = 16;

  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  dac_frame_scheduler_if #(.DATA_W(DW), .PH_W(7)) bus ();

  dac_frame_scheduler #(
    .FRAME_LEN    (FL),
    .INTERP_RATIO (IR),
    .REQ_LEAD     (RL),
    .DATA_W       (DW)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sample_out"},   32'(bus.sample_out),   32'd0);
    check({tag, "_underrun"},     32'(bus.underrun),     32'd0);
    check({tag, "_underrun_cnt"}, 32'(bus.underrun_cnt), 32'd0);
    check({tag, "_running"},      32'(bus.running),      32'd0);
    check({tag, "_phase"},        32'(bus.phase),        32'd0);
    check({tag, "_s_ready"},      32'(bus.s_ready),      32'd0);
    check({tag, "_frame_stb"},    32'(bus.frame_stb),    32'd0);
    check({tag, "_interp_stb"},   32'(bus.interp_stb),   32'd0);
  endtask

  // Scoreboard monitor: one expected entry per frame strobe.
  always @(negedge clk_in) begin
    if (!reset) begin
      if (bus.frame_stb) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_frame", 32'd1, 32'd0);
        end else begin
          check("sb_frame", 32'({bus.sample_out, bus.underrun, bus.underrun_cnt}), exp_q.pop_front());
        end
      end
      if (bus.underrun) check("underrun_only_with_frame", 32'(bus.frame_stb), 32'd1);
    end
  end

  // Runs one RUN frame from phase 0. With give=1, s_valid rises at phase at_ph and is held
  // until the handshake; that sample is expected at the next frame strobe. With give=0 an
  // underrun is expected there instead.
  task automatic run_frame(input bit give, input logic [DW-1:0] d, input int at_ph);
    int n_ip = 0;
    int n_ok = 0;
    bit done = 0;
    check("frame_start_phase", 32'(bus.phase), 32'd0);
    if (!give) begin
      m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
      exp_q.push_back(32'({{DW{1'b0}}, 1'b1, m_cnt}));
    end
    for (int c = 0; c < FL; c++) begin
      if (bus.interp_stb) begin
        n_ip++;
        if (c % (FL / IR) == 0) n_ok++;
      end
      if (give && c == at_ph) begin
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        if (at_ph < FL - RL) check("ready_outside_window", 32'(bus.s_ready), 32'd0);
      end
      if (bus.s_valid && bus.s_ready && !done) begin
        done = 1;
        exp_q.push_back(32'({d, 1'b0, m_cnt}));
      end
      tick();
      if (done && bus.s_valid) begin
        bus.s_valid = 1'b0;
        if (bus.phase != 0) check("ready_drops_after_accept", 32'(bus.s_ready), 32'd0);
      end
    end
    if (give && !done) begin
      bus.s_valid = 1'b0;
      check("handshake_timeout", 32'd0, 32'd1);
    end
    check("interp_per_frame", 32'(n_ip * 256 + n_ok), 32'(IR * 256 + IR));
  endtask

  // From PRIME: single handshake, then expect the RUN entry with frame_stb.
  task automatic prime_start(input logic [DW-1:0] d);
    check("prime_ready", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    exp_q.push_back(32'({d, 1'b0, m_cnt}));
    tick();
    bus.s_valid = 1'b0;
    check("start_frame_stb",  32'(bus.frame_stb),  32'd1);
    check("start_interp_stb", 32'(bus.interp_stb), 32'd1);
    check("start_sample_out", 32'(bus.sample_out), 32'(d));
    check("start_running",    32'(bus.running),    32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    m_cnt       = 8'd0;
    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    bus.enable = 1'b1;
    tick();
    prime_start(16'h1234);

    run_frame(1'b1, 16'h0001, 120);
    run_frame(1'b1, 16'h0002, 120);
    run_frame(1'b1, 16'h0003, 120);
    run_frame(1'b0, 16'h0000, 0);
    run_frame(1'b1, 16'h0004, 120);
    run_frame(1'b1, 16'h7FFF, 127);
    run_frame(1'b1, 16'hBEEF, 100);
    repeat (300) run_frame(1'b0, 16'h0000, 0);
    check("underrun_cnt_saturated", 32'(bus.underrun_cnt), 32'd255);

    // Stop request mid-frame; a sample offered late in this frame is discarded.
    for (int c = 0; c < FL; c++) begin
      if (c == 50)  bus.enable = 1'b0;
      if (c == 100) check("stop_frame_still_running", 32'(bus.running), 32'd1);
      if (c == 120) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0BAD;
      end
      tick();
      bus.s_valid = 1'b0;
    end
    check("stop_running",      32'(bus.running),      32'd0);
    check("stop_sample_out",   32'(bus.sample_out),   32'd0);
    check("stop_frame_stb",    32'(bus.frame_stb),    32'd0);
    check("stop_underrun",     32'(bus.underrun),     32'd0);
    check("stop_underrun_cnt", 32'(bus.underrun_cnt), 32'd255);
    check("stop_phase",        32'(bus.phase),        32'd0);
    repeat (4) tick();
    check("stop_stays_idle", 32'(bus.running), 32'd0);

    // Re-enable asserted on the wrap cycle: IDLE first, PRIME one cycle later.
    bus.enable = 1'b1;
    tick();
    prime_start(16'h0055);
    for (int c = 0; c < FL; c++) begin
      if (c == 10)     bus.enable = 1'b0;
      if (c == FL - 1) bus.enable = 1'b1;
      tick();
    end
    check("reassert_idle_running", 32'(bus.running), 32'd0);
    check("reassert_idle_ready",   32'(bus.s_ready), 32'd0);
    tick();
    check("reassert_prime_running", 32'(bus.running), 32'd0);

    // Reset in the middle of a frame.
    prime_start(16'h0077);
    repeat (37) tick();
    check("midrun_phase", 32'(bus.phase), 32'd37);
    reset = 1'b1;
    tick();
    check_idle("midrun_reset");
    bus.enable = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
